keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Upstream front end of the keylock: scans a 4x4 active-low matrix keypad, synchronises and debounces the row lines, and delivers each accepted key press to the lock controller as a 4-bit code with a one-cycle `rdy` strobe. Exactly one strobe per physical press. Bounce, glitches and multi-key chords are filtered here, so the controller never sees them.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column stays driven. Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans needed to accept a press or a release. Must be ≥ 1.

- `clk`  in  1  system clock
- `reset`  in  1  reset; asynchronous, active-high
- `col_drive`  out  4  column strobes, active-low, exactly one low at a time
- `row_sense`  in  4  raw row inputs, active-low, asynchronous to `clk`
- `keypress`  out  4  code of the last accepted key, `4*row + col`
- `rdy`  out  1  one-cycle pulse: `keypress` is newly valid
- `key_down`  out  1  high while an accepted key is held (debounced)

## Operation
- `row_sense` passes through a 2-flop synchroniser before any use.
- **Column scan.**
  - A divider counts 0..`SCAN_DIV`-1 and a 2-bit column index counts 0..3.
  - `col_drive` = ~(1 << col).
  - Rows are sampled into the scan accumulator on the last divider cycle of each column.
- **End of scan** (column 3, last divider cycle). The accumulated scan is classified as one of:
  - NONE: no row low.
  - SINGLE(code): exactly one key low across all 4 columns.
  - MULTI: two or more keys low.
- **FSM** (evaluated only at end of scan):
  - IDLE
    - SINGLE(c) → latch candidate=c, cnt=1, go to PRESS_DB.
    - NONE or MULTI → stay in IDLE.
  - PRESS_DB
    - SINGLE(candidate) → cnt+1. When cnt reaches `DEBOUNCE_SCANS`: go to HELD, keypress←candidate, pulse `rdy`.
    - SINGLE(other c) → candidate=c, cnt=1.
    - NONE or MULTI → go to IDLE.
  - HELD
    - NONE → cnt=1, go to REL_DB.
    - SINGLE or MULTI → stay in HELD. No new report; chords or rollover during a hold are ignored.
  - REL_DB
    - NONE → cnt+1. When cnt reaches `DEBOUNCE_SCANS`: go to IDLE.
    - SINGLE or MULTI → go back to HELD.
- **Special case `DEBOUNCE_SCANS`=1:**
  - IDLE+SINGLE goes directly to HELD and reports.
  - HELD+NONE goes directly to IDLE.
- **Outputs:**
  - `key_down` = state ∈ {HELD, REL_DB}.
  - `keypress` holds its value until the next accepted press.
- **Widths:** divider `$clog2(SCAN_DIV)`, cnt `$clog2(DEBOUNCE_SCANS+1)`. Neither counter can overflow, because both are bounded by the compares above.

## Timing
- **Reset values:** `col_drive`=4'b1110, `keypress`=0, `rdy`=0, `key_down`=0, state=IDLE, all counters 0, synchroniser flops=4'b1111.
- **Reset mid-operation:** any pending candidate is dropped and no `rdy` is issued. Scanning restarts at column 0.
- **Scan period:** 4·`SCAN_DIV` cycles.
- **Press latency:** `rdy` is asserted in the cycle after the end-of-scan evaluation that completes the `DEBOUNCE_SCANS`-th consecutive matching scan.
  - `rdy` high for exactly 1 cycle.
  - `keypress` updates in the same cycle as `rdy`.
- **Release latency:** `key_down` falls one cycle after the `DEBOUNCE_SCANS`-th consecutive NONE scan.
- **Sample setup:** a column is sampled ≥ 3 cycles after it is driven (2 synchroniser cycles + 1 settle), which holds because `SCAN_DIV` ≥ 4.
- **Successive strobes:** at least 2·`DEBOUNCE_SCANS` scans apart (press debounce plus release debounce).
- There is no back-pressure. The controller is required to sample `keypress` in the `rdy` cycle.

## Structure
- `keylock_pkg` contains:
  - Command key codes: KEY_LOCK=9, KEY_REPRO=8, KEY_CANCEL=7.
  - The scanner state enum {IDLE, PRESS_DB, HELD, REL_DB}.
  - The scan-class encoding {NONE, SINGLE, MULTI}.
- Sub-module `sync_2ff`: parameterised width, 2-flop synchroniser with asynchronous active-high reset to all-ones. It is reused for other asynchronous pins.
- The scan divider, accumulator and FSM stay in `keypad_scanner`.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3 (scan = 16 cycles). The bench keypad model drives row r low when col_drive[c] is low and key (r,c) is pressed.

1. **Reset.** Assert `reset` for 3 cycles → `col_drive`=1110, `keypress`=0, `rdy`=0, `key_down`=0. After release, `col_drive` rotates 1110→1101→1011→0111, advancing every 4 cycles.
2. **Clean press.** Hold key (1,1) for 10 scans → exactly one `rdy` pulse with `keypress`=5, after the 3rd full scan. `key_down` stays 1 until 3 NONE scans after release. No `rdy` on release.
3. **Bounce.** Press key 9 for 1 scan, release 1 scan, press 2 scans, release 1 scan, then hold → no `rdy` until 3 consecutive pressed scans. Then a single pulse with `keypress`=9.
4. **Chord.** Press keys 8 and 7 together for 10 scans → no `rdy`, `key_down`=0. Then release 7 and hold 8 → `rdy` with `keypress`=8 three scans later.
5. **Sequence to controller.** Press/release 9, then press/release 8 → two `rdy` pulses, `keypress` = 9 then 8. `keypress` stays 9 between the pulses.
6. **Reset mid-debounce.** Hold key 7 and assert `reset` after 2 scans → no `rdy`. After reset is deasserted with the key still held, `rdy` with `keypress`=7 comes 3 full scans later.

Source files
------------

// File: rtl/keylock_pkg.sv
// Shared types for the keylock front end and controller.
// Key codes, scanner states and scan classification.
package keylock_pkg;

  localparam logic [3:0] KEY_LOCK   = 4'd9;
  localparam logic [3:0] KEY_REPRO  = 4'd8;
  localparam logic [3:0] KEY_CANCEL = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } scan_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_class_t;

  typedef struct packed {
    scan_class_t cls;
    logic [3:0]  code;
  } scan_result_t;

  function automatic scan_result_t classify(input logic [15:0] keys);
    scan_result_t r;
    int n;
    r.cls  = NONE;
    r.code = '0;
    n      = 0;
    for (int i = 0; i < 16; i++) begin
      if (keys[i]) begin
        n++;
        r.code = 4'(i);
      end
    end
    if (n == 1)
      r.cls = SINGLE;
    else if (n > 1)
      r.cls = MULTI;
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Resets to all-ones so idle active-low pins read inactive.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce and chord rejection.
// Emits one rdy strobe with the key code per accepted press.
module keypad_scanner
  import keylock_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col_drive,
  input  logic [3:0] row_sense,
  output logic [3:0] keypress,
  output logic       rdy,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [DW-1:0] div;
  logic [1:0]    col;
  logic [3:0]    rows;
  logic [15:0]   acc;
  logic [15:0]   scan;
  logic          last;
  logic          eos;
  scan_result_t  res;
  scan_state_t   state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_sense),
    .q     (rows)
  );

  assign col_drive = ~(4'b0001 << col);
  assign last      = (div == DIV_LAST);
  assign eos       = last && (col == 2'd3);

  // Current column's rows merged over the earlier columns of this scan.
  always_comb begin
    scan = acc;
    for (int r = 0; r < 4; r++)
      scan[{r[1:0], col}] = ~rows[r];
  end

  assign res = classify(scan);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
      col <= '0;
      acc <= '0;
    end else if (last) begin
      div <= '0;
      col <= col + 2'd1;
      acc <= eos ? '0 : scan;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cand     <= '0;
      cnt      <= '0;
      keypress <= '0;
      rdy      <= 1'b0;
      key_down <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (eos) begin
        unique case (state)
          IDLE: begin
            if (res.cls == SINGLE) begin
              cand <= res.code;
              cnt  <= CNT_ONE;
              if (DEBOUNCE_SCANS == 1) begin
                state    <= HELD;
                keypress <= res.code;
                rdy      <= 1'b1;
                key_down <= 1'b1;
              end else begin
                state <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (res.cls == SINGLE && res.code == cand) begin
              cnt <= cnt + 1'b1;
              if (cnt == CNT_LAST) begin
                state    <= HELD;
                keypress <= cand;
                rdy      <= 1'b1;
                key_down <= 1'b1;
              end
            end else if (res.cls == SINGLE) begin
              cand <= res.code;
              cnt  <= CNT_ONE;
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (res.cls == NONE) begin
              cnt <= CNT_ONE;
              if (DEBOUNCE_SCANS == 1) begin
                state    <= IDLE;
                key_down <= 1'b0;
              end else begin
                state <= REL_DB;
              end
            end
          end
          REL_DB: begin
            if (res.cls == NONE) begin
              cnt <= cnt + 1'b1;
              if (cnt == CNT_LAST) begin
                state    <= IDLE;
                key_down <= 1'b0;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix.
// SCAN_DIV=4, DEBOUNCE_SCANS=3, so one scan is 16 cycles.
module tb_keypad_scanner;

  localparam int SCAN = 16;
  localparam int LAT  = 48;

  logic        clk;
  logic        reset;
  logic [3:0]  col_drive;
  logic [3:0]  row_sense;
  logic [3:0]  keypress;
  logic        rdy;
  logic        key_down;
  logic [15:0] pressed;

  int n_checks;
  int n_fail;
  int rdy_count;
  int wide_count;
  logic rdy_prev;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_drive (col_drive),
    .row_sense (row_sense),
    .keypress  (keypress),
    .rdy       (rdy),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_sense = 4'hf;
    for (int r = 0; r < 4; r++)
      row_sense[r] = ~|(pressed[4*r +: 4] & ~col_drive);
  end

  always @(posedge clk) begin
    if (rdy) rdy_count <= rdy_count + 1;
    if (rdy && rdy_prev) wide_count <= wide_count + 1;
    rdy_prev <= rdy;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic align();
    logic [3:0] prev;
    bit found;
    found = 0;
    prev = col_drive;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col_drive == 4'b1110 && prev == 4'b0111) found = 1;
      prev = col_drive;
    end
    if (!found) check("align", 0, 1);
  endtask

  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      @(negedge clk);
      if (rdy) lat = i;
    end
  endtask

  task automatic wait_release(output int lat);
    lat = -1;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      @(negedge clk);
      if (!key_down) lat = i;
    end
  endtask

  task automatic release_all();
    pressed = '0;
    repeat (5 * SCAN) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] keys;
    int          scans;
    int          exp_rdy;
    logic [3:0]  exp_code;
    logic        exp_down;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    int base;
    n_checks   = 0;
    n_fail     = 0;
    rdy_count  = 0;
    wide_count = 0;
    rdy_prev   = 0;
    pressed    = '0;

    vecs[0] = '{16'h0020, 10, 1, 4'd5, 1'b1};
    vecs[1] = '{16'h0200, 2, 0, 4'd5, 1'b0};
    vecs[2] = '{16'h0200, 4, 1, 4'd9, 1'b1};
    vecs[3] = '{16'h0180, 10, 0, 4'd9, 1'b0};
    vecs[4] = '{16'h0001, 5, 1, 4'd0, 1'b1};
    vecs[5] = '{16'h8000, 5, 1, 4'd15, 1'b1};
    vecs[6] = '{16'h8001, 6, 0, 4'd15, 1'b0};

    // reset values and column rotation
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset col_drive", 32'(col_drive), 32'h e);
    check("reset keypress", 32'(keypress), 0);
    check("reset rdy", 32'(rdy), 0);
    check("reset key_down", 32'(key_down), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("col0 held 4 cycles", 32'(col_drive), 32'h e);
    @(negedge clk);
    check("col1", 32'(col_drive), 32'h d);
    repeat (4) @(negedge clk);
    check("col2", 32'(col_drive), 32'h b);
    repeat (4) @(negedge clk);
    check("col3", 32'(col_drive), 32'h7);
    repeat (4) @(negedge clk);
    check("col wrap", 32'(col_drive), 32'h e);

    // clean press of key 5 with latency and release latency
    align();
    base = rdy_count;
    pressed = 16'h0020;
    wait_rdy(lat);
    check("press latency", 32'(lat), LAT);
    check("press code", 32'(keypress), 5);
    repeat (10 * SCAN - LAT) @(negedge clk);
    check("press one rdy", 32'(rdy_count - base), 1);
    check("held key_down", 32'(key_down), 1);
    align();
    pressed = '0;
    repeat (2 * SCAN) @(negedge clk);
    check("release 2 scans key_down", 32'(key_down), 1);
    wait_release(lat);
    check("release latency", 32'(lat), LAT - 2 * SCAN);
    repeat (2 * SCAN) @(negedge clk);
    check("no rdy on release", 32'(rdy_count - base), 1);

    // bounce on key 9
    align();
    base = rdy_count;
    pressed = 16'h0200;
    repeat (SCAN) @(negedge clk);
    pressed = '0;
    repeat (SCAN) @(negedge clk);
    pressed = 16'h0200;
    repeat (2 * SCAN) @(negedge clk);
    pressed = '0;
    repeat (SCAN) @(negedge clk);
    check("bounce no rdy", 32'(rdy_count - base), 0);
    pressed = 16'h0200;
    wait_rdy(lat);
    check("bounce latency", 32'(lat), LAT);
    check("bounce code", 32'(keypress), 9);
    repeat (SCAN) @(negedge clk);
    check("bounce one rdy", 32'(rdy_count - base), 1);
    release_all();

    // chord 8+7, then hold 8
    align();
    base = rdy_count;
    pressed = 16'h0180;
    repeat (10 * SCAN) @(negedge clk);
    check("chord no rdy", 32'(rdy_count - base), 0);
    check("chord key_down", 32'(key_down), 0);
    pressed = 16'h0100;
    wait_rdy(lat);
    check("chord->8 latency", 32'(lat), LAT);
    check("chord->8 code", 32'(keypress), 8);
    release_all();

    // sequence 9 then 8 to the controller
    align();
    base = rdy_count;
    pressed = 16'h0200;
    wait_rdy(lat);
    check("seq first code", 32'(keypress), 9);
    release_all();
    check("seq code between", 32'(keypress), 9);
    align();
    pressed = 16'h0100;
    wait_rdy(lat);
    check("seq second code", 32'(keypress), 8);
    release_all();
    check("seq two rdy", 32'(rdy_count - base), 2);

    // reset in the middle of press debounce
    align();
    base = rdy_count;
    pressed = 16'h0080;
    repeat (2 * SCAN) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid reset rdy low", 32'(rdy), 0);
    check("mid reset col_drive", 32'(col_drive), 32'h e);
    reset = 1'b0;
    check("mid reset no rdy", 32'(rdy_count - base), 0);
    wait_rdy(lat);
    check("post reset latency", 32'(lat), LAT);
    check("post reset code", 32'(keypress), 7);
    release_all();

    // table of hold/release patterns
    foreach (vecs[i]) begin
      align();
      base = rdy_count;
      pressed = vecs[i].keys;
      repeat (vecs[i].scans * SCAN) @(negedge clk);
      check($sformatf("vec%0d rdy count", i),
            32'(rdy_count - base), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d keypress", i),
            32'(keypress), 32'(vecs[i].exp_code));
      check($sformatf("vec%0d key_down", i),
            32'(key_down), 32'(vecs[i].exp_down));
      release_all();
      check($sformatf("vec%0d released", i), 32'(key_down), 0);
      check($sformatf("vec%0d rdy after release", i),
            32'(rdy_count - base), 32'(vecs[i].exp_rdy));
    end

    check("rdy single cycle", 32'(wide_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
